// File: rtl/pipeline_run_ctrl_pkg.sv
// Shared encodings for the pipeline run/step controller.
// Command and state values match the debug front end's command word.
package pipeline_run_ctrl_pkg;

    localparam int unsigned NB_CMD   = 2;
    localparam int unsigned NB_STATE = 3;

    typedef enum logic [NB_CMD-1:0] {
        CMD_PAUSE = 2'b00,
        CMD_RUN   = 2'b01,
        CMD_STEP  = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_e;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4,
        ST_CLEAR  = 3'd5
    } state_e;

endpackage

// File: rtl/pipeline_run_ctrl_if.sv
// Command handshake and pipeline control bundle between debug front end and controller.
interface pipeline_run_ctrl_if #(
    parameter int unsigned NB_CYCLE = 32
);
    logic                i_cmd_valid;
    logic [1:0]          i_cmd;
    logic                o_cmd_ready;
    logic                i_halt_detected;
    logic                o_pipe_enable;
    logic                o_pipe_flush;
    logic                o_halted;
    logic                o_step_done;
    logic [NB_CYCLE-1:0] o_cycle_count;

    modport master (
        output i_cmd_valid, i_cmd, i_halt_detected,
        input  o_cmd_ready, o_pipe_enable, o_pipe_flush, o_halted, o_step_done, o_cycle_count
    );

    modport slave (
        input  i_cmd_valid, i_cmd, i_halt_detected,
        output o_cmd_ready, o_pipe_enable, o_pipe_flush, o_halted, o_step_done, o_cycle_count
    );
endinterface

// File: rtl/pipe_cycle_counter.sv
// Saturating count of enabled pipeline clocks; synchronous clear.
module pipe_cycle_counter #(
    parameter int unsigned NB_CYCLE = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clear,
    input  logic                i_enable,
    output logic [NB_CYCLE-1:0] o_count
);
    logic [NB_CYCLE-1:0] count_q;
    logic [NB_CYCLE-1:0] count_d;

    // Hold at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && (count_q != {NB_CYCLE{1'b1}})) begin
            count_d = count_q + NB_CYCLE'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run/step/pause controller for the 5-stage pipeline with HALT drain and clear.
// Outputs are registered decodes of the next state, so they track the state register.
module pipeline_run_ctrl
    import pipeline_run_ctrl_pkg::*;
#(
    parameter int unsigned NB_CYCLE   = 32,
    parameter int unsigned PIPE_DEPTH = 4,
    parameter int unsigned NB_DRAIN   = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    pipeline_run_ctrl_if.slave   bus
);
    state_e              state_q, state_d;
    logic [NB_DRAIN-1:0] drain_q, drain_d;
    logic                ready_q, ready_d;
    logic                enable_q, enable_d;
    logic                flush_q, flush_d;
    logic                halted_q, halted_d;
    logic                done_q, done_d;
    logic                accept;
    cmd_e                cmd;

    assign cmd    = cmd_e'(bus.i_cmd);
    assign accept = bus.i_cmd_valid && ready_q;

    // Next-state and registered output decode.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (cmd)
                        CMD_RUN:   state_d = ST_RUN;
                        CMD_STEP:  state_d = ST_STEP;
                        CMD_CLEAR: state_d = ST_CLEAR;
                        default:   state_d = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                // HALT outranks any command presented in the same clock.
                if (bus.i_halt_detected) begin
                    state_d = ST_DRAIN;
                    drain_d = NB_DRAIN'(PIPE_DEPTH - 1);
                end else if (accept && (cmd == CMD_PAUSE)) begin
                    state_d = ST_IDLE;
                end else if (accept && (cmd == CMD_CLEAR)) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_STEP: begin
                if (bus.i_halt_detected) begin
                    state_d = ST_DRAIN;
                    drain_d = NB_DRAIN'(PIPE_DEPTH - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_d = drain_q - NB_DRAIN'(1);
                end
            end
            ST_HALTED: begin
                if (accept && (cmd == CMD_CLEAR)) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        ready_d  = (state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_HALTED);
        enable_d = (state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_DRAIN);
        flush_d  = (state_d == ST_CLEAR);
        halted_d = (state_d == ST_HALTED);
        done_d   = (state_q == ST_STEP) && (state_d == ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q  <= ST_IDLE;
            drain_q  <= '0;
            ready_q  <= 1'b1;
            enable_q <= 1'b0;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            ready_q  <= ready_d;
            enable_q <= enable_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
            done_q   <= done_d;
        end
    end

    // Count is zeroed at the edge that ends the CLEAR clock.
    pipe_cycle_counter #(
        .NB_CYCLE (NB_CYCLE)
    ) u_cycle_counter (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (flush_q),
        .i_enable (enable_q),
        .o_count  (bus.o_cycle_count)
    );

    assign bus.o_cmd_ready   = ready_q;
    assign bus.o_pipe_enable = enable_q;
    assign bus.o_pipe_flush  = flush_q;
    assign bus.o_halted      = halted_q;
    assign bus.o_step_done   = done_q;
endmodule
